// File: rtl/bist_pkg.sv
// Shared constants and types for the SRAM read-check block.
package bist_pkg;

  localparam int AW     = 8;  // SRAM address width (256 words)
  localparam int DW     = 4;  // SRAM data width
  localparam int RD_LAT = 1;  // cycles from r_en_out to valid rd_data

  // Checkerboard words; PAT_A sits where addr[0]^addr[4] is 0
  localparam logic [DW-1:0] PAT_A = 4'b1010;
  localparam logic [DW-1:0] PAT_B = 4'b0101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/chk_exp.sv
// Expected checkerboard word for an address. Shared by the checker and the
// pattern writer so both always agree on the layout.
module chk_exp #(
  parameter int AW = bist_pkg::AW,
  parameter int DW = bist_pkg::DW
) (
  input  logic [AW-1:0] addr,
  input  logic          rev,
  output logic [DW-1:0] exp_data
);
  import bist_pkg::*;

  // Pick the checkerboard phase from addr bits 0 and 4, invert for reverse pass
  always_comb begin
    exp_data = (addr[0] ^ addr[4]) ? DW'(PAT_B) : DW'(PAT_A);
    if (rev) begin
      exp_data = ~exp_data;
    end
  end

endmodule

// File: rtl/resp_chk.sv
// Read-check engine: sweeps all SRAM addresses once per pass, compares the
// returned words against the checkerboard and records the mismatch count and
// the first failing address.
//
// SRAM read timing: when r_en_out is high in a cycle, rd_data carries the word
// at that cycle's addr_out exactly RD_LAT cycles later. There is no
// backpressure; one read is issued per READ cycle.
module resp_chk #(
  parameter int AW     = bist_pkg::AW,
  parameter int DW     = bist_pkg::DW,
  parameter int RD_LAT = bist_pkg::RD_LAT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_in,
  input  logic          rev_in,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] addr_out,
  output logic          r_en_out,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] fail_addr,
  output logic          fail_valid,
  output logic [1:0]    dbg_state
);
  import bist_pkg::*;

  localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [AW-1:0] ADDR_LAST = '1;
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX   = {1'b1, {AW{1'b0}}};  // one per word
  localparam logic [DCW-1:0] DRAIN_INIT = DCW'(RD_LAT - 1);
  localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

  state_t          state;
  logic            rev_q;
  logic [DCW-1:0]  drain_cnt;

  // Address/valid pipeline lined up with the SRAM read latency
  logic [AW-1:0]   pipe_addr [RD_LAT];
  logic [RD_LAT-1:0] pipe_vld;

  logic            active;
  logic            flush;
  logic            mismatch;
  logic [DW-1:0]   exp_data;
  logic [AW:0]     err_cnt_nxt;

  assign dbg_state = state;

  chk_exp #(
    .AW (AW),
    .DW (DW)
  ) u_chk_exp (
    .addr     (pipe_addr[RD_LAT-1]),
    .rev      (rev_q),
    .exp_data (exp_data)
  );

  // Compare only while a pass is live; dropping en_in discards what is in flight
  always_comb begin
    active      = (state == READ) || (state == DRAIN);
    flush       = active && !en_in;
    mismatch    = active && en_in && pipe_vld[RD_LAT-1] && (rd_data != exp_data);
    err_cnt_nxt = err_cnt;
    if (mismatch && (err_cnt != CNT_MAX)) begin
      err_cnt_nxt = err_cnt + CNT_ONE;
    end
  end

  // Delay issued address/valid by RD_LAT stages; flushed on abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_addr[i] <= '0;
      end
    end else if (flush) begin
      pipe_vld <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
      pipe_vld[0]  <= r_en_out;
      pipe_addr[0] <= addr_out;
    end
  end

  // Pass sequencing plus result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_out   <= '0;
      r_en_out   <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_addr  <= '0;
      fail_valid <= 1'b0;
      rev_q      <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          r_en_out <= 1'b0;
          if (en_in) begin
            state      <= READ;
            r_en_out   <= 1'b1;
            addr_out   <= '0;
            rev_q      <= rev_in;
            err_cnt    <= '0;
            fail_addr  <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
            done       <= 1'b0;
          end
        end
        READ: begin
          if (!en_in) begin
            state    <= IDLE;
            r_en_out <= 1'b0;
          end else if (addr_out == ADDR_LAST) begin
            state     <= DRAIN;
            r_en_out  <= 1'b0;
            drain_cnt <= DRAIN_INIT;
          end else begin
            addr_out <= addr_out + ADDR_ONE;
          end
        end
        DRAIN: begin
          r_en_out <= 1'b0;
          if (!en_in) begin
            state <= IDLE;
          end else if (drain_cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_cnt_nxt == '0);
          end else begin
            drain_cnt <= drain_cnt - DRAIN_ONE;
          end
        end
        DONE: begin
          r_en_out <= 1'b0;
          if (!en_in) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          r_en_out <= 1'b0;
        end
      endcase

      // Mismatch bookkeeping; only live in READ/DRAIN so it never meets the IDLE clear
      if (mismatch) begin
        err_cnt <= err_cnt_nxt;
        if (!fail_valid) begin
          fail_addr  <= pipe_addr[RD_LAT-1];
          fail_valid <= 1'b1;
        end
      end
    end
  end

endmodule
